// File: rtl/cmp_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the shared branch comparator.
// The master modport is the requester side; the slave modport is the arbiter side.
interface cmp_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [3*NUM_REQ-1:0]      req_op;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic                      rsp_br_en;
  logic                      rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_br_en, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_br_en, rsp_err
  );
endinterface

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one branch comparator, with a one-entry registered result slot.
// Optional per-requester grant and stall counters are compiled in with CMP_ARB_STATS_EN.
module cmp_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cmp_arbiter_if.slave           bus
`ifdef CMP_ARB_STATS_EN
  ,
  output logic [32*NUM_REQ-1:0]  grant_cnt,
  output logic [31:0]            stall_cnt
`endif
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_funct3_t;

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              br_en_q, br_en_d;
  logic              err_q, err_d;

  logic              grant_any;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   scan_idx;
  logic              slot_free;
  logic              accept;
  logic [2:0]        op_sel;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;

  function automatic logic cmp_eval(input logic [2:0] op,
                                    input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
    case (op)
      F3_BEQ:  return a == b;
      F3_BNE:  return a != b;
      F3_BLT:  return $signed(a) <  $signed(b);
      F3_BGE:  return $signed(a) >= $signed(b);
      F3_BLTU: return a <  b;
      F3_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_any && bus.req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_id  = scan_idx;
      end
    end
  end

  // The slot frees up in the same cycle the owner takes its result.
  assign slot_free     = (state_q == ST_EMPTY) || bus.rsp_ready[id_q];
  assign accept        = rst_n && slot_free && grant_any;
  assign bus.req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;

  assign op_sel = bus.req_op[3*int'(grant_id) +: 3];
  assign a_sel  = bus.req_a[DATA_W*int'(grant_id) +: DATA_W];
  assign b_sel  = bus.req_b[DATA_W*int'(grant_id) +: DATA_W];

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    br_en_d  = br_en_q;
    err_d    = err_q;
    if (accept) begin
      state_d  = ST_FULL;
      id_d     = grant_id;
      br_en_d  = cmp_eval(op_sel, a_sel, b_sel);
      err_d    = (op_sel[2:1] == 2'b01);
      rr_ptr_d = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
    end else if (state_q == ST_FULL && bus.rsp_ready[id_q]) begin
      state_d = ST_EMPTY;
      br_en_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q  <= ST_EMPTY;
      id_q     <= '0;
      rr_ptr_q <= '0;
      br_en_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
      br_en_q  <= br_en_d;
      err_q    <= err_d;
    end
  end

  assign bus.rsp_valid = (state_q == ST_FULL) ? (NUM_REQ'(1) << id_q) : '0;
  assign bus.rsp_br_en = br_en_q;
  assign bus.rsp_err   = err_q;

`ifdef CMP_ARB_STATS_EN
  logic [31:0] grant_cnt_q [NUM_REQ];
  logic [31:0] stall_cnt_q;

  // Saturating counters; a stall is any cycle with a request pending and no grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && int'(grant_id) == i && grant_cnt_q[i] != 32'hFFFF_FFFF)
          grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
      end
      if ((|bus.req_valid) && bus.req_ready == '0 && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[32*i +: 32] = grant_cnt_q[i];
  end
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
Shares one branch comparator between NUM_REQ requesters, e.g. the EX-stage branch unit and a slt/sltu path or a second issue slot. Requesters use a valid/ready handshake. Grants are round-robin. Each compare result is registered and returned one cycle after acceptance, with per-requester response backpressure. The comparator is instantiated inside the block.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 32, operand width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous reset, active-low
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
req_op  input  3*NUM_REQ  branch_funct3_t per requester; slice i = [3i+2:3i]
req_a  input  DATA_W*NUM_REQ  operand a per requester
req_b  input  DATA_W*NUM_REQ  operand b per requester
rsp_valid  output  NUM_REQ  result valid, one-hot or zero, to the owning requester
rsp_ready  input  NUM_REQ  per-requester result accept
rsp_br_en  output  1  compare result, qualified by rsp_valid
rsp_err  output  1  unsupported op flag, qualified by rsp_valid

Behaviour:
- Reset (rst_n=0 at clk edge):
  - rsp_valid=0, rsp_br_en=0, rsp_err=0, rr_ptr=0.
  - Stats counters (if compiled) cleared.
  - req_ready forced 0 while rst_n=0.
- State: EMPTY (no held result) or FULL (result held for owner id).
- Slot free this cycle = EMPTY, or FULL with rsp_ready[id]=1. Result dequeue and new accept may occur in the same cycle.
- Grant (combinational):
  - If slot free and any req_valid, grant the first valid requester scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready = one-hot grant; otherwise 0.
  - req_ready never depends on rsp_ready of a requester other than the current owner.
- Accept: on req_valid[g] && req_ready[g] at clk edge:
  - id<=g; rsp_br_en<=cmp(req_op[g], req_a[g], req_b[g]); rsp_err<=op_unsupported.
  - State FULL; rr_ptr<=(g+1) mod NUM_REQ.
- Latency: result visible one cycle after accept. Throughput: one compare per cycle while the owner holds rsp_ready=1.
- Hold: FULL and rsp_ready[id]=0 → rsp_valid, rsp_br_en, rsp_err and id stable; no grants.
- Dequeue without new accept → EMPTY, rsp_valid=0.
- Compare semantics:
  - beq/bne use equality.
  - blt/bge are signed.
  - bltu/bgeu are unsigned.
  - All are full DATA_W width.
- funct3 3'b010 or 3'b011: rsp_br_en=0, rsp_err=1, still completes as a normal response.
- Requester rule: once req_valid is asserted, it and the payload stay stable until accepted. The arbiter does not check this; a bench assertion does.
- rr_ptr advances only on accept, never on idle cycles.
- Single requester valid: granted every free cycle regardless of rr_ptr.
- rst_n low mid-operation: the held result is dropped (rsp_valid=0 next cycle), with no partial response afterwards.

Optional Feature:
- Macro: CMP_ARB_STATS_EN.
- Defined: adds outputs grant_cnt (32*NUM_REQ, per-requester accept count) and stall_cnt (32, cycles with any req_valid high and req_ready all zero).
  - Counters saturate at 32'hFFFF_FFFF.
  - Cleared on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single requester 0, op beq, a=b=32'h1234, rsp_ready=1 → req_ready[0]=1 in the same cycle; next cycle rsp_valid=2'b01, rsp_br_en=1, rsp_err=0.
- Both valid every cycle from reset, rsp_ready=2'b11, blt with a=32'hFFFF_FFFF, b=1 → grants alternate 0,1,0,1; every rsp_br_en=1; one result per cycle.
- Same operands with bltu → rsp_br_en=0; bge with a=32'h8000_0000, b=0 → 0; bgeu → 1.
- Req0 accepted, rsp_ready[0]=0 for 3 cycles with req1 valid:
  - rsp_valid=2'b01 held stable, req_ready=0 throughout.
  - The cycle rsp_ready[0]=1, req_ready[1]=1.
  - Next cycle rsp_valid=2'b10.
- req_op=3'b010 on requester 1 → rsp_valid=2'b10, rsp_br_en=0, rsp_err=1.
- rst_n=0 while FULL → next cycle rsp_valid=0, req_ready=0. After release, both valid → requester 0 granted first. With CMP_ARB_STATS_EN, counters read 0 after reset and grant_cnt matches the accepts seen.
